// File: rtl/cla_pipelined_adder.sv
// -----------------------------------------------------------------------------
// cla_pipelined_adder
//
// Pipelined carry-lookahead adder/subtractor. A WIDTH-bit operation is split
// into BLOCK-bit lookahead slices, one slice resolved per pipeline stage, with
// the slice carry registered between stages. The last stage register is the
// output register. All stages advance together under a single enable, so a
// stalled consumer freezes the whole pipe and results leave in acceptance
// order.
//
// Parameters
//   WIDTH  operand/result width; must be a positive multiple of BLOCK
//   BLOCK  bits resolved per stage (lookahead slice width)
//   STAGES derived pipeline depth, WIDTH/BLOCK
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   in_valid       operation present on data_operandA/B and sub
//   in_ready       operation accepted this cycle (combinational)
//   data_operandA  first operand
//   data_operandB  second operand
//   sub            0: A+B, 1: A-B computed as A + ~B + 1
//   out_valid      result fields valid
//   out_ready      consumer takes the result this cycle
//   data_result    sum/difference modulo 2^WIDTH
//   c_out          carry out of the MSB (1 = no borrow when subtracting)
//   overflow       signed overflow (MSB carry-in XOR carry-out)
// -----------------------------------------------------------------------------
module cla_pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             c_out,
    output logic             overflow
);

    // Guard the divisions below so a bad BLOCK reaches the check instead of
    // dividing by zero.
    localparam int BlockSafe = (BLOCK > 0) ? BLOCK : 1;
    localparam int STAGES    = (WIDTH / BlockSafe > 0) ? WIDTH / BlockSafe : 1;

    if (BLOCK < 1 || WIDTH < 1 || (WIDTH % BlockSafe) != 0) begin : gen_bad_params
        $error("cla_pipelined_adder: WIDTH (%0d) must be a positive multiple of BLOCK (%0d)",
               WIDTH, BLOCK);
    end

    // Full lookahead: every carry is a flat sum of generate/propagate products
    // rather than a ripple through the previous carry.
    function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] gen,
                                                 input logic [BLOCK-1:0] prop,
                                                 input logic             cin);
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = gen[i];
            term   = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & gen[j]);
                term   = term & prop[j];
            end
            c[i+1] = c[i+1] | (term & cin);
        end
        return c;
    endfunction

    // Stage registers. Operand registers are shifted right by BLOCK per stage
    // so the next unresolved slice is always at the bottom; the partial result
    // is shifted right with each new slice entering at the top, so after the
    // last stage every slice sits at its final position.
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic              ovf_q;

    // Per-stage inputs and next-state values.
    logic [WIDTH-1:0]  opa_in [STAGES];
    logic [WIDTH-1:0]  opb_in [STAGES];
    logic [WIDTH-1:0]  res_in [STAGES];
    logic [STAGES-1:0] valid_in;
    logic [STAGES-1:0] carry_in;

    logic [BLOCK-1:0]  slice_a   [STAGES];
    logic [BLOCK-1:0]  slice_b   [STAGES];
    logic [BLOCK-1:0]  slice_sum [STAGES];
    logic [BLOCK:0]    chain     [STAGES];

    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [STAGES-1:0] carry_d;
    logic              ovf_d;

    logic adv;

    // The whole pipe moves unless a result is waiting on the consumer.
    assign adv      = !valid_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    // Stage input selection: stage 1 takes the ports (B inverted for
    // subtraction, sub as carry-in), later stages take the previous register.
    always_comb begin
        opa_in[0]   = data_operandA;
        opb_in[0]   = data_operandB ^ {WIDTH{sub}};
        res_in[0]   = '0;
        carry_in[0] = sub;
        valid_in[0] = in_valid & adv;
        for (int s = 1; s < STAGES; s++) begin
            opa_in[s]   = opa_q[s-1];
            opb_in[s]   = opb_q[s-1];
            res_in[s]   = res_q[s-1];
            carry_in[s] = carry_q[s-1];
            valid_in[s] = valid_q[s-1];
        end
    end

    // Slice arithmetic for every stage.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            slice_a[s]   = opa_in[s][BLOCK-1:0];
            slice_b[s]   = opb_in[s][BLOCK-1:0];
            chain[s]     = lookahead(slice_a[s] & slice_b[s], slice_a[s] | slice_b[s],
                                     carry_in[s]);
            slice_sum[s] = slice_a[s] ^ slice_b[s] ^ chain[s][BLOCK-1:0];
            carry_d[s]   = chain[s][BLOCK];
            opa_d[s]     = opa_in[s] >> BLOCK;
            opb_d[s]     = opb_in[s] >> BLOCK;
            res_d[s]     = (res_in[s] >> BLOCK) | (WIDTH'(slice_sum[s]) << (WIDTH - BLOCK));
        end
        // The MSB lives in the top bit of the final slice.
        ovf_d = chain[STAGES-1][BLOCK] ^ chain[STAGES-1][BLOCK-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                opa_q[s] <= '0;
                opb_q[s] <= '0;
                res_q[s] <= '0;
            end
        end else if (adv) begin
            valid_q <= valid_in;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < STAGES; s++) begin
                opa_q[s] <= opa_d[s];
                opb_q[s] <= opb_d[s];
                res_q[s] <= res_d[s];
            end
        end
    end

    assign out_valid   = valid_q[STAGES-1];
    assign data_result = res_q[STAGES-1];
    assign c_out       = carry_q[STAGES-1];
    assign overflow    = ovf_q;

    // Final-stage operand registers only ever hold shifted-out zeros.
    logic unused_last_ops;
    assign unused_last_ops = ^{opa_q[STAGES-1], opb_q[STAGES-1]};

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipelined_adder
//
// Directed bench for cla_pipelined_adder: a 32/8 instance (four stages) and an
// 8/8 instance (single stage). Inputs are driven just after the falling edge
// and outputs sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cla_pipelined_adder;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        in_valid;
    logic        in_ready;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic        c_out;
    logic        overflow;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] result;

    logic        iv8;
    logic        ir8;
    logic        sub8;
    logic        ov8;
    logic        c8;
    logic        o8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  r8;

    int          n_errors = 0;
    int          n_checks = 0;
    int          n_out    = 0;
    logic [33:0] exp_q [$];
    logic        acc;
    int          idx;

    logic [31:0] sa [8] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0003,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'h00FF_00FF};
    logic [31:0] sb [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 32'h0000_000A,
                            32'h8000_0000, 32'hFFFF_FFFF, 32'h8765_4321, 32'h0000_FF01};
    logic        ss [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    always #5 clock = ~clock;

    cla_pipelined_adder #(
        .WIDTH(32),
        .BLOCK(8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_operandA(op_a),
        .data_operandB(op_b),
        .sub          (sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_result  (result),
        .c_out        (c_out),
        .overflow     (overflow)
    );

    cla_pipelined_adder #(
        .WIDTH(8),
        .BLOCK(8)
    ) dut8 (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (iv8),
        .in_ready     (ir8),
        .data_operandA(a8),
        .data_operandB(b8),
        .sub          (sub8),
        .out_valid    (ov8),
        .out_ready    (1'b1),
        .data_result  (r8),
        .c_out        (c8),
        .overflow     (o8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: {overflow, carry, result}. Overflow from operand/result signs.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [31:0] bb;
        logic [32:0] t;
        logic        o;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {32'd0, s};
        o  = (a[31] == bb[31]) && (t[31] != a[31]);
        return {o, t[32], t[31:0]};
    endfunction

    // One cycle on the 32-bit DUT with scoreboard tracking.
    task automatic step(input logic iv, input logic [31:0] ai, input logic [31:0] bi,
                        input logic si, input logic ordy, output logic accepted);
        @(negedge clock);
        in_valid  = iv;
        op_a      = ai;
        op_b      = bi;
        sub       = si;
        out_ready = ordy;
        #1;
        accepted = iv && in_ready;
        if (accepted) exp_q.push_back(model(ai, bi, si));
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
            else check("result", 64'({overflow, c_out, result}), 64'(exp_q.pop_front()));
        end
    endtask

    // Single operation on an empty 32-bit pipe: latency, value, drain.
    task automatic single(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                          input logic si, input logic [33:0] want);
        int l;
        @(negedge clock);
        in_valid  = 1'b1;
        op_a      = ai;
        op_b      = bi;
        sub       = si;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        l = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid) begin
                l = i + 1;
                break;
            end
            @(negedge clock);
        end
        check({tag, "_latency"}, 64'(l), 64'd4);
        check({tag, "_value"}, 64'({overflow, c_out, result}), 64'(want));
        @(negedge clock);
        #1;
        check({tag, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    // Single operation on the 8-bit, one-stage instance.
    task automatic single8(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                           input logic si, input logic [9:0] want);
        @(negedge clock);
        iv8  = 1'b1;
        a8   = ai;
        b8   = bi;
        sub8 = si;
        #1;
        check({tag, "_in_ready"}, 64'(ir8), 64'd1);
        @(negedge clock);
        iv8 = 1'b0;
        #1;
        check({tag, "_latency1"}, 64'(ov8), 64'd1);
        check({tag, "_value"}, 64'({o8, c8, r8}), 64'(want));
        @(negedge clock);
        #1;
        check({tag, "_drained"}, 64'(ov8), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        iv8       = 1'b0;
        a8        = '0;
        b8        = '0;
        sub8      = 1'b0;

        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_outputs", 64'({overflow, c_out, result}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single-stage configuration.
        single8("w8_ff_plus_1", 8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
        single8("w8_7f_plus_1", 8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80});
        single8("w8_0_minus_1", 8'h00, 8'h01, 1'b1, {1'b0, 1'b0, 8'hFF});
        single8("w8_80_minus_1", 8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 8'h7F});

        // Directed 32-bit vectors, expected values computed by hand.
        single("add_pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        single("add_full_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 32'h0});
        single("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        single("sub_neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
        single("add_zero", 32'h0000_0000, 32'h0000_0000, 1'b0, {1'b0, 1'b0, 32'h0});
        single("sub_equal", 32'h0000_0007, 32'h0000_0007, 1'b1, {1'b0, 1'b1, 32'h0});
        single("add_mixed", 32'h1234_5678, 32'h8765_4321, 1'b0, {1'b0, 1'b0, 32'h9999_9999});
        single("add_neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0});

        // Streaming: 8 back-to-back operations then drain.
        for (int k = 0; k < 12; k++) begin
            if (k < 8) step(1'b1, sa[k], sb[k], ss[k], 1'b1, acc);
            else step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_out_valid", 64'(out_valid), 64'(k >= 4));
        end
        check("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure with input gaps: stall three cycles once the pipe is full.
        idx   = 0;
        n_out = 0;
        for (int k = 0; k < 24; k++) begin
            logic        ordy;
            logic        gap;
            logic [31:0] ai;
            logic [31:0] bi;
            ordy = !(k >= 4 && k < 7);
            gap  = (k == 8) || (k == 10) || (k == 11) || (k == 15);
            ai   = 32'hFFFF_FFF0 + 32'(idx * 3);
            bi   = 32'h0000_0011 + 32'(idx * 32'h0101_0101);
            step((idx < 10) && !gap, ai, bi, idx[0], ordy, acc);
            if (acc) idx++;
            if (k >= 4 && k < 7) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'({overflow, c_out, result}),
                      64'(model(32'hFFFF_FFF0, 32'h0000_0011, 1'b0)));
            end
        end
        check("bp_accepted", 64'(idx), 64'd10);
        check("bp_delivered", 64'(n_out), 64'd10);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with a result at the output and three more in flight.
        for (int k = 0; k < 4; k++) step(1'b1, sa[k], sb[k], ss[k], 1'b1, acc);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_pre_out_valid", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", 64'({overflow, c_out, result}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end

        // Pipe still works after reset.
        n_out = 0;
        step(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, acc);
        for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        check("post_rst_delivered", 64'(n_out), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
